booth_r4_mult: RTL and testbench



---
 rtl/mult_pkg.sv | 33 +++
 rtl/booth_r4_recode.sv | 21 ++
 rtl/booth_r4_mult.sv | 158 +++++++++++++++
 tb/tb_booth_r4_mult.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mult_pkg.sv
// Shared types and helpers for the radix-4 Booth multiplier.
package mult_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef enum logic [2:0] {
        R_ZERO = 3'd0,
        R_P1   = 3'd1,
        R_P2   = 3'd2,
        R_M1   = 3'd3,
        R_M2   = 3'd4
    } recode_t;

    // Addend mux select (0 / Mx / 2Mx) plus negate via invert and carry-in.
    typedef struct packed {
        logic [1:0] sel;
        logic       neg;
    } addend_ctrl_t;

    localparam logic [1:0] SEL_ZERO = 2'd0;
    localparam logic [1:0] SEL_MX   = 2'd1;
    localparam logic [1:0] SEL_2MX  = 2'd2;

    // Two bits retired per step over the (width+2)-bit extended multiplier.
    function automatic int unsigned steps(input int unsigned width);
        return width / 2 + 1;
    endfunction

endpackage

// File: rtl/booth_r4_recode.sv
// Radix-4 Booth digit recoder for the triplet {P[1], P[0], g}.
module booth_r4_recode
    import mult_pkg::*;
(
    input  logic [2:0] triplet,
    output recode_t    code
);

    always_comb begin
        code = R_ZERO;
        unique case (triplet)
            3'b000, 3'b111: code = R_ZERO;
            3'b001, 3'b010: code = R_P1;
            3'b011:         code = R_P2;
            3'b100:         code = R_M2;
            3'b101, 3'b110: code = R_M1;
            default:        code = R_ZERO;
        endcase
    end

endmodule

// File: rtl/booth_r4_mult.sv
// Sequential radix-4 Booth multiplier, fixed latency, valid/ready on both sides.
module booth_r4_mult
    import mult_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 is_signed,
    input  logic [WIDTH-1:0]     m,
    input  logic [WIDTH-1:0]     q,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   product,
    output logic                 busy
);

    localparam int unsigned E  = WIDTH + 2;
    localparam int unsigned AW = E + 2;
    localparam int unsigned N  = steps(WIDTH);
    localparam int unsigned CW = $clog2(N + 1);
    localparam int unsigned LO = 2 * WIDTH - E;

    if ((WIDTH % 2) != 0 || WIDTH < 4) begin : g_width_check
        $error("booth_r4_mult: WIDTH must be even and at least 4");
    end

    state_t            state;
    state_t            state_nxt;
    logic [CW-1:0]     cnt;
    logic [AW-1:0]     acc;
    logic [E-1:0]      p;
    logic              g;
    logic [E-1:0]      mx;

    logic              accept;
    logic              last_step;
    recode_t           code;
    addend_ctrl_t      ctrl;
    logic [AW-1:0]     mx_ext;
    logic [AW-1:0]     mag;
    logic [AW-1:0]     addend;
    logic [AW-1:0]     a_sum;
    logic [AW-1:0]     a_nxt;
    logic [E-1:0]      p_nxt;
    logic              g_nxt;

    assign accept    = in_valid && in_ready;
    assign last_step = (state == RUN) && (cnt == CW'(N - 1));

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (accept)    state_nxt = RUN;
            RUN:     if (last_step) state_nxt = DONE;
            DONE:    if (out_ready) state_nxt = IDLE;
            default:                state_nxt = IDLE;
        endcase
    end

    // State decodes; in_ready depends on state only
    always_comb begin
        in_ready = 1'b0;
        busy     = 1'b0;
        in_ready = (state == IDLE);
        busy     = (state == RUN);
    end

    booth_r4_recode u_recode (
        .triplet ({p[1], p[0], g}),
        .code    (code)
    );

    // Booth digit to mux select and negate
    always_comb begin
        ctrl = '{sel: SEL_ZERO, neg: 1'b0};
        unique case (code)
            R_ZERO:  ctrl = '{sel: SEL_ZERO, neg: 1'b0};
            R_P1:    ctrl = '{sel: SEL_MX,   neg: 1'b0};
            R_P2:    ctrl = '{sel: SEL_2MX,  neg: 1'b0};
            R_M1:    ctrl = '{sel: SEL_MX,   neg: 1'b1};
            R_M2:    ctrl = '{sel: SEL_2MX,  neg: 1'b1};
            default: ctrl = '{sel: SEL_ZERO, neg: 1'b0};
        endcase
    end

    // Partial-product add followed by a 2-bit arithmetic shift of {A,P,g}
    always_comb begin
        mx_ext = {{2{mx[E-1]}}, mx};
        mag    = '0;
        unique case (ctrl.sel)
            SEL_MX:  mag = mx_ext;
            SEL_2MX: mag = {mx_ext[AW-2:0], 1'b0};
            default: mag = '0;
        endcase
        addend = ctrl.neg ? ~mag : mag;
        a_sum  = acc + addend + AW'(ctrl.neg);
        a_nxt  = {{2{a_sum[AW-1]}}, a_sum[AW-1:2]};
        p_nxt  = {a_sum[1:0], p[E-1:2]};
        g_nxt  = p[1];
    end

    // Datapath and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt       <= '0;
            acc       <= '0;
            p         <= '0;
            g         <= 1'b0;
            mx        <= '0;
            out_valid <= 1'b0;
            product   <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        cnt <= '0;
                        acc <= '0;
                        p   <= {{2{is_signed & q[WIDTH-1]}}, q};
                        g   <= 1'b0;
                        mx  <= {{2{is_signed & m[WIDTH-1]}}, m};
                    end
                end
                RUN: begin
                    acc <= a_nxt;
                    p   <= p_nxt;
                    g   <= g_nxt;
                    cnt <= cnt + CW'(1);
                    if (last_step) begin
                        product   <= {a_nxt[LO-1:0], p_nxt};
                        out_valid <= 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_booth_r4_mult.sv
// Scoreboard bench for booth_r4_mult at WIDTH=32 and WIDTH=8.
module tb_booth_r4_mult;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        iv32, ir32, s32, ov32, or32, busy32;
    logic [31:0] m32, q32;
    logic [63:0] prod32;

    logic        iv8, ir8, s8, ov8, or8, busy8;
    logic [7:0]  m8, q8;
    logic [15:0] prod8;

    booth_r4_mult #(.WIDTH(32)) u_dut32 (
        .clk(clk), .rst(rst), .in_valid(iv32), .in_ready(ir32), .is_signed(s32),
        .m(m32), .q(q32), .out_valid(ov32), .out_ready(or32), .product(prod32), .busy(busy32)
    );

    booth_r4_mult #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst(rst), .in_valid(iv8), .in_ready(ir8), .is_signed(s8),
        .m(m8), .q(q8), .out_valid(ov8), .out_ready(or8), .product(prod8), .busy(busy8)
    );

    int passed = 0;
    int total  = 0;
    logic [63:0] exp_q32[$];
    logic [15:0] exp_q8[$];

    function automatic logic [63:0] ref64(input logic [31:0] a, input logic [31:0] b, input bit s);
        logic [63:0] x, y;
        x = s ? {{32{a[31]}}, a} : {32'd0, a};
        y = s ? {{32{b[31]}}, b} : {32'd0, b};
        return x * y;
    endfunction

    function automatic logic [15:0] ref16(input logic [7:0] a, input logic [7:0] b, input bit s);
        logic [15:0] x, y;
        x = s ? {{8{a[7]}}, a} : {8'd0, a};
        y = s ? {{8{b[7]}}, b} : {8'd0, b};
        return x * y;
    endfunction

    task automatic wait_ready32();
        int k = 0;
        while (!ir32 && k < 50) begin @(negedge clk); k++; end
        if (!ir32) begin
            total++;
            $display("FAIL wait_ready32: in_ready=%0b required 1", ir32);
        end
    endtask

    // Issue one 32-bit op, check latency, busy span and product, then handshake.
    task automatic do_op32(input logic [31:0] a, input logic [31:0] b, input bit s, input string name);
        int n, busy_cnt;
        logic [63:0] exp;
        wait_ready32();
        m32 = a; q32 = b; s32 = s; iv32 = 1'b1;
        exp_q32.push_back(ref64(a, b, s));
        @(negedge clk);
        iv32 = 1'b0;
        n = 1;
        busy_cnt = int'(busy32);
        while (!ov32 && n < 60) begin
            @(negedge clk);
            n++;
            busy_cnt += int'(busy32);
        end
        total++;
        if (!ov32) begin
            $display("FAIL %s timeout: out_valid=%0b required 1", name, ov32);
            void'(exp_q32.pop_front());
            return;
        end
        passed++;
        exp = exp_q32.pop_front();
        total++;
        if (prod32 !== exp) $display("FAIL %s product: got %h required %h", name, prod32, exp);
        else passed++;
        total++;
        if (n - 1 != 17) $display("FAIL %s latency: got %0d required 17", name, n - 1);
        else passed++;
        total++;
        if (busy_cnt != 17) $display("FAIL %s busy cycles: got %0d required 17", name, busy_cnt);
        else passed++;
        or32 = 1'b1;
        @(negedge clk);
        or32 = 1'b0;
        total++;
        if (ov32 !== 1'b0 || ir32 !== 1'b1)
            $display("FAIL %s handshake: out_valid=%0b in_ready=%0b required 0/1", name, ov32, ir32);
        else passed++;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        iv32 = 1'b1; m32 = 32'd3; q32 = 32'd3; s32 = 1'b0; or32 = 1'b0;
        iv8 = 1'b1;  m8 = 8'd3;  q8 = 8'd3;  s8 = 1'b0;  or8 = 1'b0;
        repeat (3) @(negedge clk);
        total++;
        if (ir32 !== 1'b1 || ov32 !== 1'b0 || busy32 !== 1'b0 || prod32 !== 64'd0)
            $display("FAIL reset32: ir=%0b ov=%0b busy=%0b prod=%h required 1/0/0/0", ir32, ov32, busy32, prod32);
        else passed++;
        total++;
        if (ir8 !== 1'b1 || ov8 !== 1'b0 || busy8 !== 1'b0 || prod8 !== 16'd0)
            $display("FAIL reset8: ir=%0b ov=%0b busy=%0b prod=%h required 1/0/0/0", ir8, ov8, busy8, prod8);
        else passed++;
        iv32 = 1'b0; iv8 = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        total++;
        if (busy32 !== 1'b0 || busy8 !== 1'b0)
            $display("FAIL reset_no_accept: busy32=%0b busy8=%0b required 0/0", busy32, busy8);
        else passed++;
    endtask

    task automatic test_vectors32();
        do_op32(32'hFFFFFFF9, 32'd3,        1'b1, "s_m7x3");
        do_op32(32'h80000000, 32'h80000000, 1'b1, "s_minxmin");
        do_op32(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, "s_m1xm1");
        do_op32(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, "u_maxxmax");
        do_op32(32'h80000000, 32'd2,        1'b0, "u_msbx2");
        do_op32(32'h7FFFFFFF, 32'h80000000, 1'b1, "s_maxxmin");
        do_op32(32'd0,        32'h12345678, 1'b1, "s_zero");
    endtask

    task automatic test_backpressure();
        int n = 0;
        logic [63:0] exp;
        wait_ready32();
        m32 = 32'h0001_2345; q32 = 32'hFFFF_FF00; s32 = 1'b1; iv32 = 1'b1;
        exp_q32.push_back(ref64(32'h0001_2345, 32'hFFFF_FF00, 1'b1));
        @(negedge clk);
        iv32 = 1'b0;
        repeat (3) @(negedge clk);
        iv32 = 1'b1; m32 = 32'd99; q32 = 32'd77;
        @(negedge clk);
        iv32 = 1'b0;
        while (!ov32 && n < 60) begin @(negedge clk); n++; end
        exp = exp_q32.pop_front();
        for (int i = 0; i < 10; i++) begin
            iv32 = (i % 3 == 0);
            total++;
            if (ov32 !== 1'b1 || ir32 !== 1'b0 || prod32 !== exp)
                $display("FAIL bp_hold[%0d]: ov=%0b ir=%0b prod=%h required 1/0/%h", i, ov32, ir32, prod32, exp);
            else passed++;
            @(negedge clk);
        end
        iv32 = 1'b0;
        or32 = 1'b1;
        @(negedge clk);
        or32 = 1'b0;
        total++;
        if (ir32 !== 1'b1 || ov32 !== 1'b0 || prod32 !== exp)
            $display("FAIL bp_release: ir=%0b ov=%0b prod=%h required 1/0/%h", ir32, ov32, prod32, exp);
        else passed++;
        @(negedge clk);
        total++;
        if (busy32 !== 1'b0 || ov32 !== 1'b0)
            $display("FAIL bp_ignored_pulses: busy=%0b ov=%0b required 0/0", busy32, ov32);
        else passed++;
    endtask

    task automatic test_reset_midrun();
        wait_ready32();
        m32 = 32'h1234_5678; q32 = 32'h0BAD_F00D; s32 = 1'b0; iv32 = 1'b1;
        @(negedge clk);
        iv32 = 1'b0;
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        total++;
        if (ir32 !== 1'b1 || busy32 !== 1'b0 || ov32 !== 1'b0 || prod32 !== 64'd0)
            $display("FAIL midrun_reset: ir=%0b busy=%0b ov=%0b prod=%h required 1/0/0/0", ir32, busy32, ov32, prod32);
        else passed++;
        do_op32(32'd5, 32'd6, 1'b1, "after_reset_5x6");
    endtask

    // Inputs held valid; minimum issue interval between results must be N+2.
    task automatic test_back_to_back();
        int got = 0, issued = 0, n = 0, last_t = -1;
        logic [63:0] exp;
        or32 = 1'b1;
        iv32 = 1'b1;
        while (got < 3 && n < 200) begin
            if (ov32) begin
                exp = exp_q32.pop_front();
                total++;
                if (prod32 !== exp) $display("FAIL b2b_product[%0d]: got %h required %h", got, prod32, exp);
                else passed++;
                if (last_t >= 0) begin
                    total++;
                    if (n - last_t != 19) $display("FAIL b2b_interval[%0d]: got %0d required 19", got, n - last_t);
                    else passed++;
                end
                last_t = n;
                got++;
            end
            if (ir32) begin
                if (issued < 3) begin
                    m32 = $urandom; q32 = $urandom; s32 = issued[0];
                    exp_q32.push_back(ref64(m32, q32, s32));
                    issued++;
                end else begin
                    iv32 = 1'b0;
                end
            end
            @(negedge clk);
            n++;
        end
        iv32 = 1'b0;
        or32 = 1'b0;
        total++;
        if (got != 3) $display("FAIL b2b_count: got %0d required 3", got);
        else passed++;
        @(negedge clk);
    endtask

    task automatic do_op8(input logic [7:0] a, input logic [7:0] b, input bit s);
        int n = 0;
        logic [15:0] exp;
        m8 = a; q8 = b; s8 = s; iv8 = 1'b1;
        exp_q8.push_back(ref16(a, b, s));
        @(negedge clk);
        iv8 = 1'b0;
        n = 1;
        while (!ov8 && n < 30) begin @(negedge clk); n++; end
        exp = exp_q8.pop_front();
        total++;
        if (!ov8 || prod8 !== exp || n - 1 != 5)
            $display("FAIL w8 %0s %h*%h: prod=%h lat=%0d required %h lat 5", s ? "s" : "u", a, b, prod8, n - 1, exp);
        else passed++;
        or8 = 1'b1;
        @(negedge clk);
        or8 = 1'b0;
    endtask

    task automatic test_sweep8();
        logic [7:0] corners [5];
        corners[0] = 8'h00; corners[1] = 8'h01; corners[2] = 8'h7F;
        corners[3] = 8'h80; corners[4] = 8'hFF;
        for (int s = 0; s < 2; s++)
            for (int i = 0; i < 5; i++)
                for (int j = 0; j < 5; j++)
                    do_op8(corners[i], corners[j], s[0]);
        for (int k = 0; k < 1200; k++)
            do_op8(8'($urandom), 8'($urandom), k[0]);
    endtask

    initial begin
        test_reset();
        test_vectors32();
        test_backpressure();
        test_reset_midrun();
        test_back_to_back();
        test_sweep8();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
